// File: rtl/prefix_adder_tester.sv
// Stimulus/response tester for a registered prefix-adder wrapper: drives a/b with a
// directed-then-LFSR vector stream and checks sum/cout after a fixed pipeline latency.
module prefix_adder_tester #(
   parameter int          WIDTH       = 16,
   parameter int          LATENCY     = 2,
   parameter int          NUM_VECTORS = 256,
   parameter logic [31:0] SEED        = 32'hACE1_1234
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] sum,
   input  logic             cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [15:0]      first_err_idx,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic             v;
      logic [15:0]      idx;
      logic [WIDTH:0]   sum;
   } dl_t;

   localparam logic [31:0] PAT5       = 32'h5555_5555;
   localparam logic [31:0] PATA       = 32'hAAAA_AAAA;
   localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
   localparam logic [15:0] DRAIN_LAST = 16'(LATENCY - 1);
   localparam int          TAIL       = LATENCY - 1;

   state_t           state, state_n;
   logic [15:0]      vec_idx, nxt_idx, drain_cnt;
   logic [31:0]      lfsr, lfsr_step;
   logic [WIDTH-1:0] nxt_a, nxt_b;
   logic [WIDTH:0]   exp_sum;
   logic             mismatch;
   dl_t              dl [LATENCY];

   // start is a one-cycle request with no acknowledge: it is acted on only at an
   // edge where the state is IDLE or DONE and silently dropped otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_n = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (vec_idx == LAST_IDX) state_n = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (drain_cnt == DRAIN_LAST) state_n = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) state_n = ST_RUN;
         end
         default:  state_n = ST_IDLE;
      endcase
      pass      = done && (err_count == 16'd0);
      dbg_state = state;
   end

   // Next vector: directed patterns for k=1..3, then one LFSR step per vector.
   always_comb begin
      nxt_idx   = vec_idx + 16'd1;
      lfsr_step = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      nxt_a     = lfsr_step[WIDTH-1:0];
      nxt_b     = lfsr_step[31:32-WIDTH];
      case (nxt_idx)
         16'd1: begin nxt_a = '1; nxt_b = WIDTH'(1); end
         16'd2: begin nxt_a = '1; nxt_b = '1; end
         16'd3: begin nxt_a = PAT5[WIDTH-1:0]; nxt_b = PATA[WIDTH-1:0]; end
         default: ;
      endcase
      exp_sum  = {1'b0, a} + {1'b0, b};
      mismatch = dl[TAIL].v && ({cout, sum} != dl[TAIL].sum);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a             <= '0;
         b             <= '0;
         lfsr          <= SEED;
         vec_idx       <= '0;
         drain_cnt     <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         for (int i = 0; i < LATENCY; i++) dl[i].v <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a             <= '0;
                  b             <= '0;
                  lfsr          <= SEED;
                  vec_idx       <= '0;
                  drain_cnt     <= '0;
                  err_count     <= '0;
                  first_err_idx <= '0;
                  for (int i = 0; i < LATENCY; i++) dl[i].v <= 1'b0;
               end
            end
            ST_RUN, ST_DRAIN: begin
               // The entry for the vector now on a/b enters at this edge, so it
               // reaches the tail exactly LATENCY cycles after the vector appeared.
               dl[0].v   <= (state == ST_RUN);
               dl[0].idx <= vec_idx;
               dl[0].sum <= exp_sum;
               for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
               if (mismatch) begin
                  if (err_count != 16'hFFFF) err_count     <= err_count + 16'd1;
                  if (err_count == 16'd0)    first_err_idx <= dl[TAIL].idx;
               end
               if (state == ST_RUN && vec_idx != LAST_IDX) begin
                  vec_idx <= nxt_idx;
                  a       <= nxt_a;
                  b       <= nxt_b;
                  if (nxt_idx >= 16'd4) lfsr <= lfsr_step;
               end else begin
                  a <= '0;
                  b <= '0;
               end
               if (state == ST_RUN) drain_cnt <= '0;
               else                 drain_cnt <= drain_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/prefix_adder_tester.md
Name: prefix_adder_tester

Overview:
Self-checking stimulus/response block for the other end of the registered prefix-adder wrapper interface: it drives a/b and consumes sum/cout.
- Generates a directed-then-pseudorandom operand stream and computes the expected sum/cout internally.
- Aligns the expected result to the DUT pipeline latency, compares, and reports error count and first failing vector index.
- Used in silicon-bringup and FPGA characterization harnesses around the adder_*_wrapper family.

Parameters:
WIDTH, 16, operand width (2..32).
LATENCY, 2, cycles from an operand appearing on a/b to its result appearing on sum/cout (2 matches a wrapper that registers inputs and outputs).
NUM_VECTORS, 256, vectors per run (>= 4, <= 65535).
SEED, 32'hACE1_1234, initial LFSR state (non-zero).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle run request, honoured only in IDLE or DONE
a  out  WIDTH  operand A to DUT, registered
b  out  WIDTH  operand B to DUT, registered
sum  in  WIDTH  DUT sum
cout  in  1  DUT carry-out
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE, held until next start or reset
pass  out  1  done && err_count==0
err_count  out  16  mismatching vectors, saturates at 16'hFFFF
first_err_idx  out  16  index of first mismatching vector; meaningful only when err_count!=0

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; a=b=0; busy=done=pass=0; err_count=first_err_idx=0.
  - LFSR=SEED; delay-line valid bits cleared.
  - Reset mid-run aborts with no report.
- FSM transitions:
  - IDLE/DONE --start--> RUN. Counters, error state, LFSR and delay line are cleared at this edge.
  - RUN: one vector per cycle, index k = 0..NUM_VECTORS-1. After vector NUM_VECTORS-1 -> DRAIN.
  - DRAIN: exactly LATENCY cycles, a=b=0, no new expected entries -> DONE.
  - DONE: done=1, holds all results.
  - start in RUN/DRAIN is ignored.
- Vector sequence:
  - k=0: (0, 0).
  - k=1: (all-ones, 1).
  - k=2: (all-ones, all-ones).
  - k=3: (0x..5555, 0x..AAAA), truncated to WIDTH.
  - k>=4: from a 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, advanced once per vector from k=4. a=lfsr[WIDTH-1:0], b=lfsr[31:32-WIDTH].
- Timing: vector k is on a/b during RUN cycle k, i.e. it is registered at the edge that enters that cycle.
- Expected value: {cout,sum} = a+b at WIDTH+1 bits. It is pushed with a valid bit and index k into a LATENCY-deep shift register.
- Compare: when the delay-line output is valid, sample sum/cout in that cycle (cycle k+LATENCY) and compare all WIDTH+1 bits.
  - On mismatch: err_count++ (saturating).
  - If this is the first mismatch of the run: first_err_idx=k.
- The final compare occurs in the last DRAIN cycle. DONE is entered the next edge with all results final.
- Total run duration: start edge -> done=1 after NUM_VECTORS+LATENCY+1 edges.
- Compares never occur outside RUN/DRAIN. Inputs sum/cout are ignored in IDLE/DONE.

Test Plan:
1. Reset, then idle 5 cycles -> a=b=0, busy=done=pass=0, err_count=0.
2. Correct 16-bit LATENCY=2 wrapper, NUM_VECTORS=8, pulse start -> a/b show 0000/0000, FFFF/0001, FFFF/FFFF, 5555/AAAA, then LFSR values; busy for 10 cycles; done=1 and pass=1 11 edges after start; err_count=0.
3. Same setup, but the bench inverts sum[0] in the cycle the k=2 result is sampled -> err_count=1, first_err_idx=2, pass=0.
4. cout forced to 0 -> first_err_idx=1 (FFFF+0001 expects cout=1), err_count>=2 (k=1 and k=2 both fail).
5. DUT with latency 1 on the (0,0)/(FFFF,1) sequence -> err_count!=0, first_err_idx<=1. Then a second start with the correct DUT -> counters cleared, pass=1.
6. start pulsed during RUN -> ignored, run length unchanged. rst_n=0 at vector 5 -> next cycle IDLE, a=b=0, err_count=0, done=0.
